// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Brief    : Multi-read-port register file with a pending-write scoreboard,
//            optional same-cycle write-to-read forwarding and a registered
//            count of pending registers. Register 0 is hardwired to zero.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  output logic [NRD*DATA_W-1:0]  rd_data,
  output logic [NRD-1:0]         rd_busy,
  input  logic                   wb_en,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [1:0]             wb_sel,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic [DATA_W-1:0]      link_pc,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam int         c_nreg     = 1 << ADDR_W;
  localparam logic [1:0] c_sel_alu  = 2'b00;
  localparam logic [1:0] c_sel_mem  = 2'b01;
  localparam logic [1:0] c_sel_link = 2'b10;

  logic [DATA_W-1:0] r_regs [c_nreg];
  logic [c_nreg-1:0] r_pend;
  logic [ADDR_W:0]   r_cnt;

  logic [DATA_W-1:0] w_wdata;
  logic              w_wr_ok;
  logic              w_iss_ok;
  logic [c_nreg-1:0] w_pend_nxt;
  logic [ADDR_W:0]   w_cnt_nxt;

  // Write-data source select; the reserved code never reaches a register
  always_comb begin
    w_wdata = '0;
    case (wb_sel)
      c_sel_alu:  w_wdata = alu_result;
      c_sel_mem:  w_wdata = mem_data;
      c_sel_link: w_wdata = link_pc;
      default:    w_wdata = '0;
    endcase
  end

  // Register 0 is excluded from both writes and issues
  assign w_wr_ok  = wb_en && (wb_sel != 2'b11) && (wb_addr != '0);
  assign w_iss_ok = iss_en && (iss_addr != '0);

  // Next scoreboard: write-back clears first, so a same-address issue wins
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_ok)
      w_pend_nxt[wb_addr] = 1'b0;
    if (w_iss_ok)
      w_pend_nxt[iss_addr] = 1'b1;
  end

  // Population count of the next scoreboard so the count tracks the bits
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < c_nreg; i++)
      w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_pend_nxt[i]};
  end

  // Register storage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_nreg; i++)
        r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[wb_addr] <= w_wdata;
    end
  end

  // Scoreboard bits and their registered count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign pend_cnt = r_cnt;

  // Independent combinational read ports with optional forwarding
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_fwd;
    logic              w_iss_hit;

    assign w_ra      = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_fwd     = (BYPASS != 0) && w_wr_ok && (w_ra == wb_addr);
    assign w_iss_hit = w_iss_ok && (iss_addr == w_ra);

    assign rd_data[k*DATA_W +: DATA_W] = reset ? '0
                                       : (w_fwd ? w_wdata : r_regs[w_ra]);
    assign rd_busy[k] = reset ? 1'b0
                      : ((w_fwd && !w_iss_hit) ? 1'b0 : r_pend[w_ra]);
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_sb
// Brief    : Directed bench for reg_file_sb; a forwarding and a non-forwarding
//            instance share stimulus and are checked against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NR*AW-1:0] rd_addr = '0;
  logic          wb_en = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [1:0]    wb_sel = '0;
  logic [DW-1:0] alu_result = '0;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] link_pc = '0;
  logic          iss_en = 1'b0;
  logic [AW-1:0] iss_addr = '0;

  logic [NR*DW-1:0] byp_data, nob_data;
  logic [NR-1:0]    byp_busy, nob_busy;
  logic [AW:0]      byp_cnt, nob_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [DW-1:0] m_regs [32];
  logic          m_pend [32];

  always #5 clock = ~clock;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(1)) u_dut_byp (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(byp_data),
    .rd_busy(byp_busy), .wb_en(wb_en), .wb_addr(wb_addr), .wb_sel(wb_sel),
    .alu_result(alu_result), .mem_data(mem_data), .link_pc(link_pc),
    .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(byp_cnt));

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(0)) u_dut_nob (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(nob_data),
    .rd_busy(nob_busy), .wb_en(wb_en), .wb_addr(wb_addr), .wb_sel(wb_sel),
    .alu_result(alu_result), .mem_data(mem_data), .link_pc(link_pc),
    .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(nob_cnt));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] sel_data();
    case (wb_sel)
      2'b00:   return alu_result;
      2'b01:   return mem_data;
      default: return link_pc;
    endcase
  endfunction

  function automatic logic write_ok();
    return wb_en && (wb_sel != 2'b11) && (wb_addr != 0);
  endfunction

  // Model update: architectural rules applied at each edge
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (write_ok()) begin
        m_regs[wb_addr] = sel_data();
        m_pend[wb_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0)
        m_pend[iss_addr] = 1'b1;
    end
  end

  // Compare both instances against the model mid-cycle
  always @(negedge clock) begin : cmp
    logic [AW-1:0] a;
    logic          fwd, ihit;
    logic [DW-1:0] e_byp, e_nob;
    logic          b_byp, b_nob;
    int            cnt;
    for (int k = 0; k < NR; k++) begin
      a     = rd_addr[k*AW +: AW];
      fwd   = write_ok() && (a == wb_addr);
      ihit  = iss_en && (iss_addr != 0) && (iss_addr == a);
      e_nob = reset ? '0 : m_regs[a];
      e_byp = reset ? '0 : (fwd ? sel_data() : m_regs[a]);
      b_nob = reset ? 1'b0 : m_pend[a];
      b_byp = reset ? 1'b0 : ((fwd && !ihit) ? 1'b0 : m_pend[a]);
      chk($sformatf("byp_data%0d", k), 64'(byp_data[k*DW +: DW]), 64'(e_byp));
      chk($sformatf("nob_data%0d", k), 64'(nob_data[k*DW +: DW]), 64'(e_nob));
      chk($sformatf("byp_busy%0d", k), 64'(byp_busy[k]), 64'(b_byp));
      chk($sformatf("nob_busy%0d", k), 64'(nob_busy[k]), 64'(b_nob));
    end
    cnt = 0;
    for (int i = 0; i < 32; i++)
      cnt += int'(m_pend[i]);
    chk("byp_cnt", 64'(byp_cnt), 64'(cnt));
    chk("nob_cnt", 64'(nob_cnt), 64'(cnt));
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
    #1;
  endtask

  task automatic idle();
    wb_en  = 1'b0;
    iss_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end

    // Reset state
    mid();
    chk("rst_data", 64'(byp_data), 64'h0);
    chk("rst_cnt", 64'(byp_cnt), 64'h0);
    next_cycle();
    reset = 1'b0;

    // ALU write to r5, read back on both ports
    wb_en = 1'b1; wb_sel = 2'b00; wb_addr = 5'd5; alu_result = 32'hDEADBEEF;
    next_cycle();
    idle();
    rd_addr = {5'd5, 5'd5};
    mid();
    chk("r5_p0", 64'(byp_data[31:0]), 64'hDEADBEEF);
    chk("r5_p1", 64'(byp_data[63:32]), 64'hDEADBEEF);
    chk("r5_busy", 64'(byp_busy), 64'h0);

    // Write and issue to r0 are both ignored
    next_cycle();
    wb_en = 1'b1; wb_sel = 2'b01; wb_addr = 5'd0; mem_data = 32'h12345678;
    iss_en = 1'b1; iss_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    mid();
    chk("r0_byp", 64'(byp_data[31:0]), 64'h0);
    next_cycle();
    idle();
    mid();
    chk("r0_after", 64'(byp_data[63:32]), 64'h0);
    chk("r0_cnt", 64'(byp_cnt), 64'h0);

    // Forwarding of a link write to r31
    next_cycle();
    wb_en = 1'b1; wb_sel = 2'b00; wb_addr = 5'd31; alu_result = 32'h11111111;
    next_cycle();
    wb_sel = 2'b10; link_pc = 32'h00400008; rd_addr = {5'd31, 5'd31};
    mid();
    chk("fwd_byp", 64'(byp_data[31:0]), 64'h00400008);
    chk("fwd_nob_old", 64'(nob_data[31:0]), 64'h11111111);
    next_cycle();
    idle();
    mid();
    chk("fwd_nob_new", 64'(nob_data[31:0]), 64'h00400008);

    // Scoreboard: issue r7, r8; issue-wins collision on r7; retire r8
    next_cycle();
    iss_en = 1'b1; iss_addr = 5'd7;
    next_cycle();
    iss_addr = 5'd8;
    next_cycle();
    idle();
    rd_addr = {5'd8, 5'd7};
    mid();
    chk("sb_cnt2", 64'(byp_cnt), 64'd2);
    chk("sb_busy7", 64'(byp_busy[0]), 64'd1);
    next_cycle();
    wb_en = 1'b1; wb_sel = 2'b00; wb_addr = 5'd7; alu_result = 32'h77;
    iss_en = 1'b1; iss_addr = 5'd7;
    mid();
    chk("sb_coll_busy", 64'(byp_busy[0]), 64'd1);
    next_cycle();
    idle();
    mid();
    chk("sb_coll_cnt", 64'(byp_cnt), 64'd2);
    chk("sb_coll_data", 64'(byp_data[31:0]), 64'h77);
    next_cycle();
    wb_en = 1'b1; wb_addr = 5'd8; alu_result = 32'h88;
    mid();
    chk("sb_fwd_busy8", 64'(byp_busy[1]), 64'd0);
    next_cycle();
    idle();
    mid();
    chk("sb_cnt1", 64'(byp_cnt), 64'd1);

    // Reserved select leaves pending r9 untouched
    next_cycle();
    iss_en = 1'b1; iss_addr = 5'd9;
    next_cycle();
    idle();
    wb_en = 1'b1; wb_sel = 2'b11; wb_addr = 5'd9; alu_result = 32'h99;
    rd_addr = {5'd9, 5'd9};
    next_cycle();
    idle();
    mid();
    chk("r9_data", 64'(byp_data[63:32]), 64'h0);
    chk("r9_busy", 64'(byp_busy[1]), 64'd1);
    chk("r9_cnt", 64'(byp_cnt), 64'd2);

    // Write r4 while issuing r10, then reset asynchronously mid-cycle
    next_cycle();
    wb_en = 1'b1; wb_sel = 2'b00; wb_addr = 5'd4; alu_result = 32'hA5;
    iss_en = 1'b1; iss_addr = 5'd10;
    next_cycle();
    idle();
    rd_addr = {5'd9, 5'd4};
    mid();
    chk("pre_rst_cnt", 64'(byp_cnt), 64'd3);
    chk("pre_rst_r4", 64'(byp_data[31:0]), 64'hA5);
    reset = 1'b1;
    #1;
    chk("arst_data_byp", 64'(byp_data), 64'h0);
    chk("arst_data_nob", 64'(nob_data), 64'h0);
    chk("arst_busy", 64'({byp_busy, nob_busy}), 64'h0);
    chk("arst_cnt", 64'({byp_cnt, nob_cnt}), 64'h0);
    // Activity under reset is ignored
    wb_en = 1'b1; wb_addr = 5'd4; alu_result = 32'hFF;
    iss_en = 1'b1; iss_addr = 5'd11;
    next_cycle();
    mid();
    reset = 1'b0;
    wb_en = 1'b1; wb_sel = 2'b00; wb_addr = 5'd4; alu_result = 32'h1;
    iss_en = 1'b0;
    next_cycle();
    idle();
    rd_addr = {5'd11, 5'd4};
    mid();
    chk("post_rst_r4", 64'(nob_data[31:0]), 64'h1);
    chk("post_rst_busy11", 64'(nob_busy[1]), 64'd0);
    chk("post_rst_cnt", 64'(byp_cnt), 64'd0);

    next_cycle();
    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32, width of every register and data port.
REQ-002 Parameter ADDR_W, default 5, register address width; register count NREG = 2^ADDR_W.
REQ-003 Parameter NRD, default 2, number of independent read ports; read buses are flattened, port k occupies bits [k*W +: W].
REQ-004 Parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding enabled, 0 = disabled.
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 rd_addr  in  NRD*ADDR_W  read addresses, one per port.
REQ-008 rd_data  out  NRD*DATA_W  read data, one per port.
REQ-009 rd_busy  out  NRD  per port: addressed register has a pending write.
REQ-010 wb_en  in  1  write-back enable.
REQ-011 wb_addr  in  ADDR_W  write-back destination.
REQ-012 wb_sel  in  2  write-data source: 00 ALU, 01 MEM, 10 LINK, 11 reserved.
REQ-013 alu_result, mem_data, link_pc  in  DATA_W each  write-data candidates.
REQ-014 iss_en  in  1  issue strobe: an instruction with a register destination is dispatched.
REQ-015 iss_addr  in  ADDR_W  destination of issued instruction.
REQ-016 pend_cnt  out  ADDR_W+1  number of registers currently marked pending.

Function
REQ-017 Write data shall be alu_result (wb_sel=00), mem_data (01), link_pc (10); wb_sel=11 shall suppress the write entirely.
REQ-018 On a rising edge with wb_en=1, wb_sel!=11 and wb_addr!=0, the selected data shall be stored in register wb_addr; writes take effect one edge after presentation, no extra pipeline stage.
REQ-019 Register 0 shall always read 0 and shall never be written or marked pending.
REQ-020 Reads shall be combinational: rd_data[k] = register[rd_addr[k]] in the same cycle.
REQ-021 With BYPASS=1, if wb_en=1, wb_sel!=11, wb_addr!=0 and rd_addr[k]==wb_addr, rd_data[k] shall equal the write data being presented that cycle.
REQ-022 With BYPASS=0, rd_data[k] shall show the old value until the write edge.
REQ-023 A scoreboard of NREG pending bits shall be kept; iss_en=1 with iss_addr!=0 sets bit iss_addr on the rising edge.
REQ-024 A qualifying write (REQ-018) shall clear the pending bit of wb_addr on the same edge.
REQ-025 Simultaneous issue and write-back to the same address shall leave the bit set (issue wins).
REQ-026 Simultaneous issue and write-back to different addresses shall both take effect.
REQ-027 Issue to an already-pending register shall leave the bit set; write-back to a non-pending register shall write data and leave the bit clear.
REQ-028 rd_busy[k] shall equal the pending bit of rd_addr[k], except with BYPASS=1 it shall be 0 when the REQ-021 forwarding condition holds for that port and no same-address issue occurs that cycle.
REQ-029 pend_cnt shall be a registered population count of the pending bits, updated on the same edge as the bits, range 0..NREG-1.
REQ-030 All NRD ports shall be independent; identical addresses on several ports shall return identical data and busy.

Reset
REQ-031 On reset assertion, all registers, all pending bits and pend_cnt shall go to 0 immediately, without waiting for a clock edge.
REQ-032 While reset is high, writes and issues shall be ignored; rd_data shall read 0 and rd_busy 0.
REQ-033 Reset asserted mid-operation shall discard every in-flight pending mark; the first edge after release shall behave normally.

Verification
REQ-034 Reset, then write 0xDEADBEEF (ALU) to r5, next cycle read r5 on port 0 and r5 on port 1 -> both 0xDEADBEEF, busy 0.
REQ-035 Write mem_data 0x12345678 to r0 and iss_en to r0 -> r0 reads 0, pend_cnt 0.
REQ-036 BYPASS=1: write link_pc 0x00400008 to r31 while reading r31 -> rd_data 0x00400008 same cycle; BYPASS=0 -> old value until next cycle.
REQ-037 Issue r7, r8 over two cycles -> pend_cnt 2, busy on r7; same-cycle write-back r7 and issue r7 -> r7 stays pending, pend_cnt 2; write-back r8 -> pend_cnt 1.
REQ-038 wb_sel=11 with wb_en=1 to pending r9 -> r9 unchanged, still pending.
REQ-039 Assert reset asynchronously mid-cycle with 3 pending and r4=0xA5 -> all outputs 0 before next edge; after release, write r4=0x1 succeeds.
